// File: rtl/dict_loader_pkg.sv
// Shared definitions for the dictionary loader: FSM encoding, header layout
// and default field widths, also used by the controller side.
package dict_loader_pkg;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_HDR   = 3'd1,
        ST_LOAD1 = 3'd2,
        ST_LOAD2 = 3'd3,
        ST_LOAD3 = 3'd4,
        ST_CHK   = 3'd5,
        ST_DONE  = 3'd6
    } dl_state_e;

    localparam int HDR_CNT1_LSB = 0;
    localparam int HDR_CNT2_LSB = 8;
    localparam int HDR_CNT3_LSB = 16;
    localparam int HDR_CNT_W    = 8;

    // Remaining-entry counters must hold a full 8-bit count plus capacity 256
    localparam int REM_W = 9;

    localparam logic [31:0] WORD_BYTES = 32'd4;

    localparam int DEF_FIELD1_KEY_WIDTH = 3;
    localparam int DEF_FIELD2_KEY_WIDTH = 6;
    localparam int DEF_FIELD3_KEY_WIDTH = 7;
    localparam int DEF_FIELD1_VAL_WIDTH = 7;
    localparam int DEF_FIELD2_VAL_WIDTH = 12;
    localparam int DEF_FIELD3_VAL_WIDTH = 13;

    function automatic logic count_over(input logic [HDR_CNT_W-1:0] cnt, input int key_width);
        return (key_width < HDR_CNT_W) && (int'(cnt) > (1 << key_width));
    endfunction

    function automatic logic [REM_W-1:0] clamp_count(input logic [HDR_CNT_W-1:0] cnt,
                                                      input int key_width);
        if (count_over(cnt, key_width))
            return REM_W'(1 << key_width);
        return {1'b0, cnt};
    endfunction

endpackage

// File: rtl/dict_loader_mem_port_arb.sv
// Memory port sharing: controller passthrough while idle, loader ownership
// from the cycle start is accepted until the loader drops busy.
module mem_port_arb (
    input  logic        owned,
    input  logic        take,
    input  logic        loader_valid,
    input  logic [31:0] loader_addr,
    input  logic        ctrl_valid,
    input  logic [31:0] ctrl_addr,
    output logic        ctrl_ready,
    output logic [31:0] ctrl_rdata,
    output logic        mem_valid,
    output logic [31:0] mem_addr,
    input  logic        mem_ready,
    input  logic [31:0] mem_rdata
);

    // The start cycle masks the controller so no request is issued that the
    // loader would then inherit mid-handshake.
    assign mem_valid  = owned ? loader_valid : (ctrl_valid & ~take);
    assign mem_addr   = owned ? loader_addr  : ctrl_addr;
    assign ctrl_ready = (owned | take) ? 1'b0 : mem_ready;
    assign ctrl_rdata = mem_rdata;

endmodule

// File: rtl/dict_loader.sv
// Loads three dictionaries from a memory image (header + entry words).
// Optional trailing checksum word check enabled by DICT_LOADER_CHECKSUM_EN.
//
// state | meaning
// IDLE  | port passthrough to controller, waiting for start
// HDR   | read header word at base_addr
// LOAD1 | read dict1 entries
// LOAD2 | read dict2 entries
// LOAD3 | read dict3 entries
// CHK   | read checksum word (checksum build only)
// DONE  | one-cycle done pulse, port released
module dict_loader
    import dict_loader_pkg::*;
#(
    parameter int FIELD1_KEY_WIDTH = DEF_FIELD1_KEY_WIDTH,
    parameter int FIELD2_KEY_WIDTH = DEF_FIELD2_KEY_WIDTH,
    parameter int FIELD3_KEY_WIDTH = DEF_FIELD3_KEY_WIDTH,
    parameter int FIELD1_VAL_WIDTH = DEF_FIELD1_VAL_WIDTH,
    parameter int FIELD2_VAL_WIDTH = DEF_FIELD2_VAL_WIDTH,
    parameter int FIELD3_VAL_WIDTH = DEF_FIELD3_VAL_WIDTH
) (
    input  logic                        clk,
    input  logic                        resetn,
    input  logic                        start,
    input  logic [31:0]                 base_addr,
    output logic                        busy,
    output logic                        done,
    output logic                        error,
    input  logic                        ctrl_mem_req_valid,
    input  logic [31:0]                 ctrl_mem_req_addr,
    output logic                        ctrl_mem_req_ready,
    output logic [31:0]                 ctrl_mem_req_rdata,
    output logic                        mem_req_valid,
    output logic [31:0]                 mem_req_addr,
    input  logic                        mem_req_ready,
    input  logic [31:0]                 mem_req_rdata,
    output logic                        dict1_write_enable,
    output logic [FIELD1_VAL_WIDTH-1:0] dict1_write_val,
    output logic                        dict2_write_enable,
    output logic [FIELD2_VAL_WIDTH-1:0] dict2_write_val,
    output logic                        dict3_write_enable,
    output logic [FIELD3_VAL_WIDTH-1:0] dict3_write_val
);

    dl_state_e state_q, state_d;
    dl_state_e fin_st, after1, after2, after3;
    logic post_q, post_d;
    logic [31:0] addr_q;
    logic [REM_W-1:0] rem1_q, rem2_q, rem3_q;
    logic error_q;
    logic start_accept, busy_int, loader_valid, capture;
    logic [HDR_CNT_W-1:0] cnt1, cnt2, cnt3;
    logic unused_rdata;
`ifdef DICT_LOADER_CHECKSUM_EN
    logic [31:0] xor_q;
`endif

    assign start_accept = start && (state_q == ST_IDLE);
    assign busy_int     = (state_q != ST_IDLE) && (state_q != ST_DONE);
    assign loader_valid = busy_int && !post_q;
    assign capture      = loader_valid && mem_req_ready;

    assign busy  = busy_int;
    assign done  = (state_q == ST_DONE);
    assign error = error_q;

    assign cnt1 = mem_req_rdata[HDR_CNT1_LSB +: HDR_CNT_W];
    assign cnt2 = mem_req_rdata[HDR_CNT2_LSB +: HDR_CNT_W];
    assign cnt3 = mem_req_rdata[HDR_CNT3_LSB +: HDR_CNT_W];
    assign unused_rdata = ^mem_req_rdata;

    mem_port_arb u_arb (
        .owned        (busy_int),
        .take         (start_accept),
        .loader_valid (loader_valid),
        .loader_addr  (addr_q),
        .ctrl_valid   (ctrl_mem_req_valid),
        .ctrl_addr    (ctrl_mem_req_addr),
        .ctrl_ready   (ctrl_mem_req_ready),
        .ctrl_rdata   (ctrl_mem_req_rdata),
        .mem_valid    (mem_req_valid),
        .mem_addr     (mem_req_addr),
        .mem_ready    (mem_req_ready),
        .mem_rdata    (mem_req_rdata)
    );

    always_ff @(posedge clk) begin
        if (!resetn) begin
            state_q <= ST_IDLE;
            post_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            post_q  <= post_d;
        end
    end

    // Each word costs request, capture and one idle cycle with valid low;
    // the idle cycle is where the next state is chosen, skipping empty dicts.
    always_comb begin
`ifdef DICT_LOADER_CHECKSUM_EN
        fin_st = ST_CHK;
`else
        fin_st = ST_DONE;
`endif
        after3  = (rem3_q != '0) ? ST_LOAD3 : fin_st;
        after2  = (rem2_q != '0) ? ST_LOAD2 : after3;
        after1  = (rem1_q != '0) ? ST_LOAD1 : after2;
        state_d = state_q;
        post_d  = post_q;
        case (state_q)
            ST_IDLE: begin
                if (start_accept) begin
                    state_d = ST_HDR;
                    post_d  = 1'b0;
                end
            end
            ST_DONE: state_d = ST_IDLE;
            default: begin
                if (!post_q) begin
                    post_d = mem_req_ready;
                end else begin
                    post_d = 1'b0;
                    case (state_q)
                        ST_HDR, ST_LOAD1: state_d = after1;
                        ST_LOAD2:         state_d = after2;
                        ST_LOAD3:         state_d = after3;
                        default:          state_d = ST_DONE;
                    endcase
                end
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!resetn) begin
            addr_q             <= '0;
            rem1_q             <= '0;
            rem2_q             <= '0;
            rem3_q             <= '0;
            error_q            <= 1'b0;
            dict1_write_enable <= 1'b0;
            dict2_write_enable <= 1'b0;
            dict3_write_enable <= 1'b0;
            dict1_write_val    <= '0;
            dict2_write_val    <= '0;
            dict3_write_val    <= '0;
`ifdef DICT_LOADER_CHECKSUM_EN
            xor_q              <= '0;
`endif
        end else begin
            dict1_write_enable <= 1'b0;
            dict2_write_enable <= 1'b0;
            dict3_write_enable <= 1'b0;
            if (start_accept) begin
                addr_q  <= base_addr;
                error_q <= 1'b0;
`ifdef DICT_LOADER_CHECKSUM_EN
                xor_q   <= '0;
`endif
            end else if (capture) begin
                addr_q <= addr_q + WORD_BYTES;
`ifdef DICT_LOADER_CHECKSUM_EN
                if (state_q != ST_CHK)
                    xor_q <= xor_q ^ mem_req_rdata;
`endif
                case (state_q)
                    ST_HDR: begin
                        rem1_q <= clamp_count(cnt1, FIELD1_KEY_WIDTH);
                        rem2_q <= clamp_count(cnt2, FIELD2_KEY_WIDTH);
                        rem3_q <= clamp_count(cnt3, FIELD3_KEY_WIDTH);
                        if (count_over(cnt1, FIELD1_KEY_WIDTH) ||
                            count_over(cnt2, FIELD2_KEY_WIDTH) ||
                            count_over(cnt3, FIELD3_KEY_WIDTH))
                            error_q <= 1'b1;
                    end
                    ST_LOAD1: begin
                        rem1_q             <= rem1_q - 1'b1;
                        dict1_write_enable <= 1'b1;
                        dict1_write_val    <= mem_req_rdata[FIELD1_VAL_WIDTH-1:0];
                    end
                    ST_LOAD2: begin
                        rem2_q             <= rem2_q - 1'b1;
                        dict2_write_enable <= 1'b1;
                        dict2_write_val    <= mem_req_rdata[FIELD2_VAL_WIDTH-1:0];
                    end
                    ST_LOAD3: begin
                        rem3_q             <= rem3_q - 1'b1;
                        dict3_write_enable <= 1'b1;
                        dict3_write_val    <= mem_req_rdata[FIELD3_VAL_WIDTH-1:0];
                    end
`ifdef DICT_LOADER_CHECKSUM_EN
                    ST_CHK: begin
                        if (mem_req_rdata != xor_q)
                            error_q <= 1'b1;
                    end
`endif
                    default: ;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_dict_loader.sv
// Directed bench for dict_loader with a zero-wait memory model; checksum
// vectors are added when DICT_LOADER_CHECKSUM_EN is defined.
module tb_dict_loader;

    logic        clk = 1'b0;
    logic        resetn, start;
    logic [31:0] base_addr;
    logic        busy, done, error;
    logic        ctrl_mem_req_valid;
    logic [31:0] ctrl_mem_req_addr;
    logic        ctrl_mem_req_ready;
    logic [31:0] ctrl_mem_req_rdata;
    logic        mem_req_valid;
    logic [31:0] mem_req_addr;
    logic        mem_req_ready;
    logic [31:0] mem_req_rdata;
    logic        dict1_write_enable, dict2_write_enable, dict3_write_enable;
    logic [6:0]  dict1_write_val;
    logic [11:0] dict2_write_val;
    logic [12:0] dict3_write_val;

    logic [31:0] mem [0:4095];
    logic [31:0] q1[$], q2[$], q3[$], qa[$];
    int vectors = 0;
    int miscompares = 0;
    int ctrl_leak = 0;
    int lat, n2, k;
    logic [31:0] x;

    always #5 clk = ~clk;

    dict_loader dut (
        .clk                (clk),
        .resetn             (resetn),
        .start              (start),
        .base_addr          (base_addr),
        .busy               (busy),
        .done               (done),
        .error              (error),
        .ctrl_mem_req_valid (ctrl_mem_req_valid),
        .ctrl_mem_req_addr  (ctrl_mem_req_addr),
        .ctrl_mem_req_ready (ctrl_mem_req_ready),
        .ctrl_mem_req_rdata (ctrl_mem_req_rdata),
        .mem_req_valid      (mem_req_valid),
        .mem_req_addr       (mem_req_addr),
        .mem_req_ready      (mem_req_ready),
        .mem_req_rdata      (mem_req_rdata),
        .dict1_write_enable (dict1_write_enable),
        .dict1_write_val    (dict1_write_val),
        .dict2_write_enable (dict2_write_enable),
        .dict2_write_val    (dict2_write_val),
        .dict3_write_enable (dict3_write_enable),
        .dict3_write_val    (dict3_write_val)
    );

    // Zero-wait memory: ready follows valid by one cycle, one beat per request
    assign mem_req_rdata = mem[mem_req_addr[13:2]];
    always @(posedge clk) begin
        if (!resetn) mem_req_ready <= 1'b0;
        else         mem_req_ready <= mem_req_valid && !mem_req_ready;
    end

    always @(negedge clk) begin
        if (dict1_write_enable) q1.push_back(32'(dict1_write_val));
        if (dict2_write_enable) q2.push_back(32'(dict2_write_val));
        if (dict3_write_enable) q3.push_back(32'(dict3_write_val));
        if (mem_req_valid && mem_req_ready) qa.push_back(mem_req_addr);
        if (busy && ctrl_mem_req_ready) ctrl_leak++;
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        if (obs !== exp) begin
            miscompares++;
            $display("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [31:0] qat(input logic [31:0] q[$], input int i);
        if (i < q.size()) return q[i];
        return 32'hxxxx_xxxx;
    endfunction

    function automatic int exp_lat(input int n);
`ifdef DICT_LOADER_CHECKSUM_EN
        return 3 * (2 + n) + 1;
`else
        return 3 * (1 + n) + 1;
`endif
    endfunction

    task automatic clear_q();
        q1.delete(); q2.delete(); q3.delete(); qa.delete();
    endtask

    // lat counts cycles from the start cycle (cycle 0) to the done cycle
    task automatic run_load(input logic [31:0] base, input logic with_ctrl, output int lat_o);
        @(negedge clk);
        base_addr = base;
        start     = 1'b1;
        if (with_ctrl) begin
            ctrl_mem_req_valid = 1'b1;
            ctrl_mem_req_addr  = 32'h0000_2000;
        end
        @(posedge clk); #1;
        start = 1'b0;
        lat_o = 1;
        check("busy_after_start", 32'(busy), 32'd1);
        while (!done && lat_o < 400) begin
            @(posedge clk); #1;
            lat_o++;
        end
        check("done_seen", 32'(done), 32'd1);
        check("busy_low_at_done", 32'(busy), 32'd0);
        @(posedge clk); #1;
        check("done_one_cycle", 32'(done), 32'd0);
    endtask

    initial begin
        resetn = 1'b0; start = 1'b0; base_addr = '0;
        ctrl_mem_req_valid = 1'b0; ctrl_mem_req_addr = '0;
        for (int i = 0; i < 4096; i++) mem[i] = '0;

        // Image A at 0x100: cnt1=1 cnt2=2 cnt3=3
        mem[64] = 32'h0003_0201;
        mem[65] = 32'hDEAD_00A5;
        mem[66] = 32'h1234_5ABC;
        mem[67] = 32'hFFFF_F001;
        mem[68] = 32'h0000_3FFF;
        mem[69] = 32'hCAFE_2468;
        mem[70] = 32'h8000_1000;
        x = '0;
        for (int i = 64; i < 71; i++) x ^= mem[i];
        mem[71] = x;
        // Image B at 0x200: cnt1=9 (clamps to 8), cnt2=1, cnt3=1
        mem[128] = 32'h0001_0109;
        for (int i = 0; i < 10; i++) mem[129 + i] = 32'h100 + 32'(i);
        x = '0;
        for (int i = 128; i < 139; i++) x ^= mem[i];
        mem[139] = x;
        // Image E at 0x300: empty
        mem[192] = 32'h0;
        mem[193] = 32'h0;
        mem[2048] = 32'h5A5A_1234;

        repeat (3) @(posedge clk);
        #1;
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_done", 32'(done), 32'd0);
        check("rst_error", 32'(error), 32'd0);
        check("rst_we", {29'd0, dict1_write_enable, dict2_write_enable, dict3_write_enable}, 32'd0);
        check("rst_mem_valid", 32'(mem_req_valid), 32'd0);
        @(negedge clk);
        resetn = 1'b1;

        // Basic 1/2/3 load
        clear_q();
        run_load(32'h100, 1'b0, lat);
        check("a_latency", lat, exp_lat(6));
        check("a_n1", q1.size(), 1);
        check("a_n2", q2.size(), 2);
        check("a_n3", q3.size(), 3);
        check("a_d1_0", qat(q1, 0), 32'h25);
        check("a_d2_0", qat(q2, 0), 32'hABC);
        check("a_d2_1", qat(q2, 1), 32'h001);
        check("a_d3_0", qat(q3, 0), 32'h1FFF);
        check("a_d3_1", qat(q3, 1), 32'h0468);
        check("a_d3_2", qat(q3, 2), 32'h1000);
        check("a_addr_first", qat(qa, 0), 32'h100);
        check("a_addr_last_entry", qat(qa, 6), 32'h118);
        check("a_error", 32'(error), 32'd0);

        // Overflowing cnt1 clamps to 8 and flags error
        clear_q();
        run_load(32'h200, 1'b0, lat);
        check("b_latency", lat, exp_lat(10));
        check("b_n1", q1.size(), 8);
        check("b_n2", q2.size(), 1);
        check("b_n3", q3.size(), 1);
        check("b_d1_0", qat(q1, 0), 32'h00);
        check("b_d1_7", qat(q1, 7), 32'h07);
        check("b_d2_0", qat(q2, 0), 32'h108);
        check("b_d3_0", qat(q3, 0), 32'h109);
        check("b_addr_d2", qat(qa, 9), 32'h224);
        check("b_error", 32'(error), 32'd1);

        // Controller request pending at start is held off until done
        clear_q();
        ctrl_leak = 0;
        run_load(32'h100, 1'b1, lat);
        check("c_latency", lat, exp_lat(6));
        check("c_first_addr", qat(qa, 0), 32'h100);
        check("c_error_cleared", 32'(error), 32'd0);
        k = 0;
        while (!ctrl_mem_req_ready && k < 5) begin
            @(posedge clk); #1;
            k++;
        end
        check("c_ctrl_ready", 32'(ctrl_mem_req_ready), 32'd1);
        check("c_ctrl_rdata", ctrl_mem_req_rdata, 32'h5A5A_1234);
        check("c_ctrl_ready_while_busy", ctrl_leak, 0);
        @(negedge clk);
        ctrl_mem_req_valid = 1'b0;
        repeat (2) @(posedge clk);

        // Reset after the second dict2 write, then reload fully
        @(negedge clk);
        base_addr = 32'h100;
        start     = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        n2 = 0;
        k  = 0;
        while (n2 < 2 && k < 100) begin
            @(negedge clk);
            if (dict2_write_enable) n2++;
            k++;
        end
        check("d_two_d2_writes", n2, 2);
        resetn = 1'b0;
        @(posedge clk); #1;
        check("d_rst_busy", 32'(busy), 32'd0);
        check("d_rst_done", 32'(done), 32'd0);
        check("d_rst_error", 32'(error), 32'd0);
        check("d_rst_we", {29'd0, dict1_write_enable, dict2_write_enable, dict3_write_enable}, 32'd0);
        check("d_rst_mem_valid", 32'(mem_req_valid), 32'd0);
        check("d_rst_d2_val", 32'(dict2_write_val), 32'd0);
        clear_q();
        @(negedge clk);
        resetn = 1'b1;
        repeat (10) @(posedge clk);
        #1;
        check("d_no_strobes_after_reset", q1.size() + q2.size() + q3.size(), 0);
        check("d_idle_after_reset", 32'(busy), 32'd0);
        run_load(32'h100, 1'b0, lat);
        check("d_reload_latency", lat, exp_lat(6));
        check("d_reload_n", q1.size() * 100 + q2.size() * 10 + q3.size(), 123);
        check("d_reload_d3_2", qat(q3, 2), 32'h1000);

        // Empty header
        clear_q();
        run_load(32'h300, 1'b0, lat);
        check("e_latency", lat, exp_lat(0));
        check("e_no_writes", q1.size() + q2.size() + q3.size(), 0);
        check("e_error", 32'(error), 32'd0);

`ifdef DICT_LOADER_CHECKSUM_EN
        mem[193] = 32'h0000_0001;
        run_load(32'h300, 1'b0, lat);
        check("f_bad_checksum_error", 32'(error), 32'd1);
        check("f_latency", lat, exp_lat(0));
`endif

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
